// File: rtl/usb_rx_if.sv
// usb_rx_if: byte stream from the RX shift/EOP logic and decoded results toward FIFO/controller.
interface usb_rx_if;
   logic       byte_received;
   logic [7:0] rx_byte;
   logic       eop_detected;
   logic [6:0] buffer_occupancy;
   logic [2:0] rx_packet;
   logic       rx_transfer_active;
   logic       rx_data_ready;
   logic       rx_error;
   logic       store_rx_packet_data;
   logic [7:0] rx_packet_data;
   modport master (
      output byte_received, rx_byte, eop_detected, buffer_occupancy,
      input  rx_packet, rx_transfer_active, rx_data_ready, rx_error,
             store_rx_packet_data, rx_packet_data
   );
   modport slave (
      input  byte_received, rx_byte, eop_detected, buffer_occupancy,
      output rx_packet, rx_transfer_active, rx_data_ready, rx_error,
             store_rx_packet_data, rx_packet_data
   );
endinterface

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: validates SYNC/PID, classifies packets, streams DATA0 payload with CRC16 stripped.
module usb_rx_decoder #(
   parameter int BUF_DEPTH = 64
) (
   input logic    clk,
   input logic    rst,
   usb_rx_if.slave rx
);
   typedef enum logic [2:0] {IDLE, PID, HS_EOP, DATA, ERROR} state_t;
   state_t     state_q, state_d;
   logic [2:0] rx_packet_q, rx_packet_d;
   logic       active_q, active_d;
   logic       ready_q, ready_d;
   logic       err_q, err_d;
   logic       store_q, store_d;
   logic [7:0] data_q, data_d;
   logic [7:0] d0_q, d0_d, d1_q, d1_d;
   logic [1:0] cnt_q, cnt_d;
   logic       byte_v, eop, pid_ok, pipe_full, overflow;
   // A same-cycle byte is dropped in favour of the EOP.
   assign eop       = rx.eop_detected;
   assign byte_v    = rx.byte_received & ~rx.eop_detected;
   assign pid_ok    = rx.rx_byte[7:4] == ~rx.rx_byte[3:0];
   assign pipe_full = cnt_q == 2'd2;
   assign overflow  = pipe_full && rx.buffer_occupancy == 7'(BUF_DEPTH);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rx_packet_q <= '0;
         active_q    <= 1'b0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         store_q     <= 1'b0;
         data_q      <= '0;
         d0_q        <= '0;
         d1_q        <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rx_packet_q <= rx_packet_d;
         active_q    <= active_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         store_q     <= store_d;
         data_q      <= data_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         cnt_q       <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (byte_v) state_d = rx.rx_byte == 8'h80 ? PID : ERROR;
         PID:     if (eop) state_d = ERROR;
                  else if (byte_v) state_d = !pid_ok ? ERROR :
                                             rx.rx_byte == 8'hC3 ? DATA :
                                             (rx.rx_byte == 8'hD2 || rx.rx_byte == 8'h5A ||
                                              rx.rx_byte == 8'h1E) ? HS_EOP : ERROR;
         HS_EOP:  if (eop) state_d = IDLE;
                  else if (byte_v) state_d = ERROR;
         DATA:    if (eop) state_d = pipe_full ? IDLE : ERROR;
                  else if (byte_v && overflow) state_d = ERROR;
         ERROR:   if (eop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      rx_packet_d = rx_packet_q;
      active_d    = active_q;
      ready_d     = 1'b0;
      err_d       = err_q;
      store_d     = 1'b0;
      data_d      = data_q;
      d0_d        = d0_q;
      d1_d        = d1_q;
      cnt_d       = cnt_q;
      if (state_q == IDLE && state_d == PID) begin
         active_d    = 1'b1;
         err_d       = 1'b0;
         rx_packet_d = 3'd0;
      end
      if (state_q == PID && state_d != ERROR && byte_v) begin
         rx_packet_d = rx.rx_byte == 8'hC3 ? 3'd1 :
                       rx.rx_byte == 8'hD2 ? 3'd2 :
                       rx.rx_byte == 8'h5A ? 3'd3 : 3'd4;
         d0_d        = '0;
         d1_d        = '0;
         cnt_d       = '0;
      end
      if (state_q == HS_EOP && state_d == IDLE) active_d = 1'b0;
      if (state_q == DATA && state_d == IDLE) begin
         ready_d  = 1'b1;
         active_d = 1'b0;
      end
      // The two newest bytes stay in the pipe so the CRC16 never reaches the FIFO.
      if (state_q == DATA && state_d == DATA && byte_v) begin
         store_d = pipe_full;
         data_d  = pipe_full ? d1_q : data_q;
         d1_d    = d0_q;
         d0_d    = rx.rx_byte;
         cnt_d   = pipe_full ? cnt_q : cnt_q + 2'd1;
      end
      if (state_d == ERROR) begin
         err_d       = 1'b1;
         active_d    = 1'b0;
         rx_packet_d = 3'd0;
      end
   end
   assign rx.rx_packet            = rx_packet_q;
   assign rx.rx_transfer_active   = active_q;
   assign rx.rx_data_ready        = ready_q;
   assign rx.rx_error             = err_q;
   assign rx.store_rx_packet_data = store_q;
   assign rx.rx_packet_data       = data_q;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: directed packet sequences with hand-computed expected outputs.
module tb_usb_rx_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   usb_rx_if bus();
   usb_rx_decoder #(.BUF_DEPTH(64)) dut (.clk(clk), .rst(rst), .rx(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.byte_received = 1'b1;
      bus.rx_byte = b;
      @(negedge clk);
      bus.byte_received = 1'b0;
   endtask
   task automatic send_eop(input logic with_byte);
      @(negedge clk);
      bus.eop_detected = 1'b1;
      bus.byte_received = with_byte;
      @(negedge clk);
      bus.eop_detected = 1'b0;
      bus.byte_received = 1'b0;
   endtask
   task automatic chk_out(input string tag, input logic [2:0] pkt, input logic act,
                          input logic rdy, input logic err, input logic st);
      chk({tag, ".pkt"}, 8'(bus.rx_packet), 8'(pkt));
      chk({tag, ".act"}, 8'(bus.rx_transfer_active), 8'(act));
      chk({tag, ".rdy"}, 8'(bus.rx_data_ready), 8'(rdy));
      chk({tag, ".err"}, 8'(bus.rx_error), 8'(err));
      chk({tag, ".st"}, 8'(bus.store_rx_packet_data), 8'(st));
   endtask
   initial begin
      bus.byte_received = 1'b0;
      bus.rx_byte = '0;
      bus.eop_detected = 1'b0;
      bus.buffer_occupancy = '0;
      repeat (3) @(negedge clk);
      chk_out("reset", 3'd0, 0, 0, 0, 0);
      chk("reset.data", bus.rx_packet_data, 8'h00);
      rst = 1'b0;
      // handshake ACK
      send_byte(8'h80); chk_out("ack.sync", 3'd0, 1, 0, 0, 0);
      send_byte(8'hD2); chk_out("ack.pid", 3'd2, 1, 0, 0, 0);
      send_eop(0);      chk_out("ack.eop", 3'd2, 0, 0, 0, 0);
      // DATA0 with 3 payload bytes
      send_byte(8'h80); send_byte(8'hC3); chk_out("d3.pid", 3'd1, 1, 0, 0, 0);
      send_byte(8'h11); chk("d3.b1.st", 8'(bus.store_rx_packet_data), 8'h0);
      send_byte(8'h22); chk("d3.b2.st", 8'(bus.store_rx_packet_data), 8'h0);
      send_byte(8'h33); chk("d3.b3.st", 8'(bus.store_rx_packet_data), 8'h1);
      chk("d3.b3.data", bus.rx_packet_data, 8'h11);
      send_byte(8'hA5); chk("d3.b4.st", 8'(bus.store_rx_packet_data), 8'h1);
      chk("d3.b4.data", bus.rx_packet_data, 8'h22);
      send_byte(8'h5A); chk("d3.b5.st", 8'(bus.store_rx_packet_data), 8'h1);
      chk("d3.b5.data", bus.rx_packet_data, 8'h33);
      send_eop(0);      chk_out("d3.eop", 3'd1, 0, 1, 0, 0);
      @(negedge clk);   chk_out("d3.after", 3'd1, 0, 0, 0, 0);
      // zero-payload DATA0, then too short
      send_byte(8'h80); send_byte(8'hC3);
      send_byte(8'hAA); chk("z.b1.st", 8'(bus.store_rx_packet_data), 8'h0);
      send_byte(8'hBB); chk("z.b2.st", 8'(bus.store_rx_packet_data), 8'h0);
      send_eop(0);      chk_out("z.eop", 3'd1, 0, 1, 0, 0);
      send_byte(8'h80); send_byte(8'hC3); send_byte(8'hAA);
      send_eop(0);      chk_out("short.eop", 3'd0, 0, 0, 1, 0);
      // bad SYNC, ignored bytes, recovery
      send_byte(8'h81); chk_out("bsync", 3'd0, 0, 0, 1, 0);
      send_byte(8'h80); chk_out("bsync.ign", 3'd0, 0, 0, 1, 0);
      send_eop(0);      chk_out("bsync.eop", 3'd0, 0, 0, 1, 0);
      send_byte(8'h80); chk_out("rec1.sync", 3'd0, 1, 0, 0, 0);
      send_byte(8'h5A); send_eop(0); chk_out("rec1.nak", 3'd3, 0, 0, 0, 0);
      // bad PID nibble check
      send_byte(8'h80); send_byte(8'hC4); chk_out("bpid", 3'd0, 0, 0, 1, 0);
      send_byte(8'hC3); chk_out("bpid.ign", 3'd0, 0, 0, 1, 0);
      send_eop(0);
      send_byte(8'h80); send_byte(8'h5A); send_eop(0);
      chk_out("rec2.nak", 3'd3, 0, 0, 0, 0);
      // FIFO overflow on 3rd payload byte
      send_byte(8'h80); send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02);
      bus.buffer_occupancy = 7'd64;
      send_byte(8'h03); chk_out("ovf", 3'd0, 0, 0, 1, 0);
      bus.buffer_occupancy = 7'd0;
      send_eop(0);      chk_out("ovf.eop", 3'd0, 0, 0, 1, 0);
      // same-cycle byte+EOP in HS_EOP counts as EOP
      send_byte(8'h80); send_byte(8'hD2);
      send_eop(1);      chk_out("both", 3'd2, 0, 0, 0, 0);
      send_byte(8'h80); send_byte(8'h5A); send_eop(0);
      chk_out("both.next", 3'd3, 0, 0, 0, 0);
      // async reset mid-DATA after two stores
      send_byte(8'h80); send_byte(8'hC3);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      chk("rst.pre.st", 8'(bus.store_rx_packet_data), 8'h1);
      chk("rst.pre.data", bus.rx_packet_data, 8'h22);
      #1 rst = 1'b1;
      #1 chk_out("rst.async", 3'd0, 0, 0, 0, 0);
      chk("rst.async.data", bus.rx_packet_data, 8'h00);
      @(negedge clk); rst = 1'b0;
      send_byte(8'h80); send_byte(8'h1E); chk_out("stall.pid", 3'd4, 1, 0, 0, 0);
      send_eop(0);      chk_out("stall.eop", 3'd4, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
